// File: rtl/enable_pulse_gen_if.sv
// Button/mode inputs and enable/status outputs of the enable pulse generator.
// The slave modport is the generator side; the master modport is the driving side.
interface enable_pulse_gen_if;
  logic button_i;
  logic mode_i;
  logic enable_o;
  logic pressed_o;
  logic paused_o;

  modport slave (
    input  button_i,
    input  mode_i,
    output enable_o,
    output pressed_o,
    output paused_o
  );

  modport master (
    output button_i,
    output mode_i,
    input  enable_o,
    input  pressed_o,
    input  paused_o
  );
endinterface

// File: rtl/enable_pulse_gen.sv
// Debounces a raw push-button into a single-cycle enable pulse (step mode) or
// produces a periodic tick that the button pauses and resumes (free-run mode).
module enable_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRESCALE        = 5
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  enable_pulse_gen_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] r_btnSync;
  logic [SYNC_STAGES-1:0] r_modeSync;
  logic                   w_btnS;
  logic                   w_modeS;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cntNext;
  logic                   w_pressEvent;

  logic [PW-1:0]          r_presc;
  logic                   r_modePrev;
  logic                   r_enable;
  logic                   r_pressed;
  logic                   r_paused;

  assign w_btnS  = r_btnSync[SYNC_STAGES-1];
  assign w_modeS = r_modeSync[SYNC_STAGES-1];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_btnSync  <= '0;
      r_modeSync <= '0;
    end else begin
      r_btnSync  <= {r_btnSync[SYNC_STAGES-2:0], bus.button_i};
      r_modeSync <= {r_modeSync[SYNC_STAGES-2:0], bus.mode_i};
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // A release bounce returns to PRESSED silently, so one press yields one event
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_pressEvent = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_btnS) begin
          w_stateNext = PRESS_WAIT;
          w_cntNext   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_btnS) begin
          w_stateNext = RELEASED;
          w_cntNext   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext  = PRESSED;
          w_pressEvent = 1'b1;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!w_btnS) begin
          w_stateNext = RELEASE_WAIT;
          w_cntNext   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_btnS) begin
          w_stateNext = PRESSED;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext = RELEASED;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      default: begin
        w_stateNext = RELEASED;
        w_cntNext   = '0;
      end
    endcase
  end

  // Tick decision uses the pause flag from before the edge; a toggle lands next cycle
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_presc    <= '0;
      r_modePrev <= 1'b0;
      r_enable   <= 1'b0;
      r_pressed  <= 1'b0;
      r_paused   <= 1'b0;
    end else begin
      r_pressed  <= (w_stateNext == PRESSED) || (w_stateNext == RELEASE_WAIT);
      r_modePrev <= w_modeS;
      if (w_modeS != r_modePrev) begin
        r_presc  <= '0;
        r_paused <= 1'b0;
        r_enable <= 1'b0;
      end else if (w_modeS) begin
        r_enable <= (r_presc == PRE_LAST) && !r_paused;
        if (!r_paused) begin
          r_presc <= (r_presc == PRE_LAST) ? '0 : r_presc + 1'b1;
        end
        if (w_pressEvent) begin
          r_paused <= ~r_paused;
        end
      end else begin
        r_enable <= w_pressEvent;
        r_presc  <= '0;
        r_paused <= 1'b0;
      end
    end
  end

  assign bus.enable_o  = r_enable;
  assign bus.pressed_o = r_pressed;
  assign bus.paused_o  = r_paused;

endmodule

// File: doc/enable_pulse_gen.md
Name: enable_pulse_gen

Overview:
- Upstream stage for the board-level 4-bit counter. Turns a raw, bouncing push-button into a single-cycle `enable_o` pulse.
- Optional free-running mode produces a periodic tick instead. In that mode the button acts as pause/resume.
- `enable_o` connects directly to the counter's `enable_i`. Both blocks share `clock_i` and `reset_n_i`.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `button_i` and on `mode_i` (at least 2).
- DEBOUNCE_CYCLES, 4, stable-level cycles required after the first qualifying sample (at least 1).
- PRESCALE, 5, free-run tick period in clock cycles (at least 2). Counter width is clog2(PRESCALE).

Ports:
- clock_i  input  1  system clock, rising edge.
- reset_n_i  input  1  reset, asynchronous assert, active low.
- button_i  input  1  raw asynchronous push-button, 1 = pressed.
- mode_i  input  1  asynchronous, quasi-static. 0 = step mode, 1 = free-run mode.
- enable_o  output  1  registered one-cycle enable pulse.
- pressed_o  output  1  registered debounced button level.
- paused_o  output  1  registered free-run pause flag.

Behaviour:
- Clock and reset: one clock, `clock_i`. Reset `reset_n_i` is asynchronous and active-low.
- Reset values: all flops clear while `reset_n_i` = 0.
  - Synchronizers 0, FSM = RELEASED, debounce counter 0, prescaler 0.
  - `enable_o` = 0, `pressed_o` = 0, `paused_o` = 0.
  - Outputs go low immediately on reset assertion, not at the next clock edge.
- Synchronizers: `btn_s` and `mode_s` are the last-stage outputs of SYNC_STAGES-deep chains. Latency is SYNC_STAGES edges.
- Debounce FSM, evaluated on every rising edge:
  - RELEASED: if `btn_s` = 1, go to PRESS_WAIT with cnt = 0.
  - PRESS_WAIT:
    - if `btn_s` = 0, go to RELEASED and clear cnt;
    - else if cnt = DEBOUNCE_CYCLES-1, go to PRESSED and raise the press event;
    - else cnt++.
  - PRESSED: if `btn_s` = 0, go to RELEASE_WAIT with cnt = 0.
  - RELEASE_WAIT:
    - if `btn_s` = 1, go back to PRESSED with no press event;
    - else if cnt = DEBOUNCE_CYCLES-1, go to RELEASED;
    - else cnt++.
- Press event timing:
  - The press event needs `btn_s` = 1 on DEBOUNCE_CYCLES+1 consecutive edges.
  - Counting edges from the first one after `button_i` rises as edge 0, `enable_o` goes high after edge SYNC_STAGES+DEBOUNCE_CYCLES, for exactly one cycle.
  - Exactly one press event per debounced press. Holding the button never repeats it.
- `pressed_o` = 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
- Step mode (`mode_s` = 0):
  - `enable_o` <= press event.
  - Prescaler held at 0, `paused_o` held at 0.
- Free-run mode (`mode_s` = 1):
  - Prescaler counts 0..PRESCALE-1 and wraps to 0. It holds its value while `paused_o` = 1.
  - `enable_o` <= (prescaler = PRESCALE-1) and not `paused_o`.
  - Each press event toggles `paused_o`. Press events never drive `enable_o` directly in this mode.
- Mode change: on any `mode_s` transition, prescaler and `paused_o` clear on that edge, and `enable_o` is 0 for that cycle.
- Simultaneous events in free-run: a press event on the same edge as a tick makes the tick count only if `paused_o` was 0 before the edge. The toggle takes effect from the next edge.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
- Clean press (S=2, D=4, step mode): `button_i` rises before edge 0 and is held 20 cycles -> `enable_o` = 1 only between edges 6 and 7; `pressed_o` = 1 from edge 6.
- Press bounce: `btn_s` pattern 1,1,0,1 held -> FSM returns to RELEASED on the 0, then exactly one pulse 5 edges after the final rise of `btn_s`; no pulse from the glitch.
- Release bounce: while PRESSED, `button_i` low for 2 cycles, high 1, then low -> returns to PRESSED without a pulse; `pressed_o` drops only after 5 stable low edges of `btn_s`; no pulse on the re-press.
- Free-run (P=5): `mode_i` = 1 -> `enable_o` pulses on every 5th edge after `mode_s` rises (4 low cycles between pulses); press -> `paused_o` = 1 and no pulses; second press -> resumes from the held prescaler value.
- Reset mid-debounce: assert `reset_n_i` while in PRESS_WAIT with the button held -> all outputs 0 asynchronously; after deassertion with the button still high, a pulse arrives after the full SYNC_STAGES+DEBOUNCE_CYCLES+1 edges.
- Chained with the counter: 3 clean presses -> counter value goes 0->1->2->3, one increment per press.
